// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one LCD1602 controller between N_REQ message
// sources, with duplicate-message suppression, write timeout and hold time.
module lcd_msg_arbiter #(
  parameter int N_REQ       = 3,
  parameter int MSG_W       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  localparam int OW         = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*MSG_W-1:0] msg_i,
  output logic [N_REQ-1:0]       gnt_o,
  input  logic                   lcd_ready_i,
  output logic                   lcd_start_o,
  output logic [MSG_W-1:0]       lcd_msg_o,
  input  logic                   lcd_done_i,
  output logic [OW-1:0]          owner_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CMAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, WAIT_DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             dup_q, dup_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [MSG_W-1:0] msg_arr [N_REQ];
  logic             win_found;
  logic [OW-1:0]    win_idx;
  logic [OW-1:0]    scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_msg
      assign msg_arr[gi] = msg_i[gi*MSG_W +: MSG_W];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester after owner wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      scan_idx = OW'((int'(owner_q) + i) % N_REQ);
      if (req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    start_d = 1'b0;
    msg_d   = msg_q;
    owner_d = owner_q;
    err_d   = err_q;
    dup_d   = dup_q;
    cnt_d   = cnt_q;
    if (!lcd_ready_i) begin
      state_d = WAIT_INIT;
      dup_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_INIT: state_d = IDLE;
        IDLE: begin
          if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            owner_d        = win_idx;
            msg_d          = msg_arr[win_idx];
            // msg_q holds the last shown code whenever dup_q is set.
            if (!dup_q || (msg_arr[win_idx] != msg_q)) begin
              start_d = 1'b1;
              state_d = WAIT_DONE;
              cnt_d   = '0;
            end
          end
        end
        WAIT_DONE: begin
          if (lcd_done_i) begin
            dup_d   = 1'b1;
            state_d = HOLD;
            cnt_d   = '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            dup_d   = 1'b0;
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = WAIT_INIT;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_INIT;
      gnt_q   <= '0;
      start_q <= 1'b0;
      msg_q   <= '0;
      owner_q <= OW'(N_REQ - 1);
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      msg_q   <= msg_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign lcd_start_o = start_q;
  assign lcd_msg_o   = msg_q;
  assign owner_o     = owner_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scenario bench for lcd_msg_arbiter: grants are checked against a queue of
// expected (grant, code, start) entries pushed by each scenario.
module tb_lcd_msg_arbiter;

  localparam int N  = 3;
  localparam int MW = 4;
  localparam int H  = 4;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*MW-1:0] msg;
  logic [N-1:0]  gnt_o;
  logic          ready;
  logic          lcd_start_o;
  logic [MW-1:0] lcd_msg_o;
  logic          done;
  logic [1:0]    owner_o;
  logic          busy_o;
  logic          err_o;

  lcd_msg_arbiter #(.N_REQ(N), .MSG_W(MW), .HOLD_CYCLES(H), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_i(req), .msg_i(msg), .gnt_o(gnt_o),
    .lcd_ready_i(ready), .lcd_start_o(lcd_start_o), .lcd_msg_o(lcd_msg_o),
    .lcd_done_i(done), .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [MW-1:0] code;
    logic          start;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_at = 0;

  // Scoreboard consumer: every observed grant must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && gnt_o !== '0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_grant: got gnt=%b code=%h start=%b, expected none", gnt_o, lcd_msg_o, lcd_start_o);
      end else begin
        e = sb.pop_front();
        if (gnt_o !== e.gnt || lcd_msg_o !== e.code || lcd_start_o !== e.start) begin
          n_bad++;
          $display("FAIL grant: got gnt=%b code=%h start=%b, expected gnt=%b code=%h start=%b",
                   gnt_o, lcd_msg_o, lcd_start_o, e.gnt, e.code, e.start);
        end else begin
          $display("grant cyc=%0d gnt=%b code=%h start=%b", cyc, gnt_o, lcd_msg_o, lcd_start_o);
        end
      end
    end
  end

  function automatic exp_t mk(logic [N-1:0] g, logic [MW-1:0] c, logic s);
    exp_t r;
    r.gnt = g; r.code = c; r.start = s;
    return r;
  endfunction

  task automatic set_code(int k, logic [MW-1:0] c);
    msg[k*MW +: MW] = c;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_o !== '0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_done(int delay);
    repeat (delay) @(negedge clk);
    done = 1'b1;
    done_at = cyc;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int at, c0;
    bit ok;
    ready = 1'b0; done = 1'b0; req = 3'b001;
    set_code(0, 4'h3); set_code(1, 4'h7); set_code(2, 4'hA);
    apply_reset();
    n_cmp++;
    if (gnt_o !== 3'b000 || lcd_start_o !== 1'b0 || lcd_msg_o !== 4'h0 || owner_o !== 2'd2 ||
        busy_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got gnt=%b start=%b code=%h owner=%0d busy=%b err=%b, expected 000 0 0 2 1 0",
               gnt_o, lcd_start_o, lcd_msg_o, owner_o, busy_o, err_o);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1 || lcd_start_o !== 1'b0) begin
      n_bad++;
      $display("FAIL not_ready_hold: got busy=%b start=%b, expected 1 0", busy_o, lcd_start_o);
    end
    sb.push_back(mk(3'b001, 4'h3, 1'b1));
    c0 = cyc;
    ready = 1'b1;
    wait_grant(at);
    n_cmp++;
    if (at - c0 != 2) begin
      n_bad++;
      $display("FAIL ready_latency: got %0d cycles, expected 2", at - c0);
    end
    req = 3'b000;
    pulse_done(2);
    wait_idle(ok);
    n_cmp++;
    if (!ok || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL first_write_idle: got idle=%b err=%b, expected 1 0", ok, err_o);
    end
  endtask

  task automatic test_round_robin();
    int at;
    bit ok;
    logic [1:0] order [4];
    logic [MW-1:0] codes [4];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
    codes[0] = 4'h3; codes[1] = 4'h7; codes[2] = 4'hA; codes[3] = 4'h3;
    apply_reset();
    for (int k = 0; k < 4; k++) sb.push_back(mk(3'b001 << order[k], codes[k], 1'b1));
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(at);
      n_cmp++;
      if (at < 0 || owner_o !== order[k]) begin
        n_bad++;
        $display("FAIL rr_owner%0d: got owner=%0d at=%0d, expected owner=%0d", k, owner_o, at, order[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (at - done_at < H + 1) begin
          n_bad++;
          $display("FAIL rr_hold%0d: got gap=%0d, expected at least %0d", k, at - done_at, H + 1);
        end
      end
      if (k == 3) req = 3'b000;
      pulse_done(3);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rr_idle: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_dup_suppress();
    int at;
    bit ok;
    set_code(0, 4'h5);
    sb.push_back(mk(3'b001, 4'h5, 1'b1));
    req = 3'b001;
    wait_grant(at);
    req = 3'b000;
    pulse_done(1);
    wait_idle(ok);
    sb.push_back(mk(3'b001, 4'h5, 1'b0));
    req = 3'b001;
    wait_grant(at);
    req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (at < 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_stays_idle: got at=%0d busy=%b, expected grant and busy=0", at, busy_o);
    end
  endtask

  task automatic test_timeout();
    int at, t_err;
    bit ok;
    sb.push_back(mk(3'b010, 4'h7, 1'b1));
    req = 3'b010;
    wait_grant(at);
    req = 3'b000;
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_early: got err=%b, expected 0", err_o);
    end
    t_err = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) begin
        t_err = cyc;
        break;
      end
    end
    n_cmp++;
    if (t_err < 0 || t_err - at != T) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d cycles (err seen=%b), expected %0d", t_err - at, t_err >= 0, T);
    end
    wait_idle(ok);
    sb.push_back(mk(3'b100, 4'hA, 1'b1));
    req = 3'b100;
    wait_grant(at);
    req = 3'b000;
    n_cmp++;
    if (at < 0 || err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL grant_after_timeout: got at=%0d err=%b, expected grant and err=1", at, err_o);
    end
    pulse_done(1);
    wait_idle(ok);
  endtask

  task automatic test_ready_drop();
    int at, c0;
    bit ok;
    sb.push_back(mk(3'b001, 4'h5, 1'b1));
    req = 3'b001;
    wait_grant(at);
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1 || lcd_start_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_drop_busy: got busy=%b start=%b, expected 1 0", busy_o, lcd_start_o);
    end
    sb.push_back(mk(3'b001, 4'h5, 1'b1));
    c0 = cyc;
    ready = 1'b1;
    wait_grant(at);
    req = 3'b000;
    n_cmp++;
    if (at - c0 != 2) begin
      n_bad++;
      $display("FAIL reissue_latency: got %0d cycles, expected 2", at - c0);
    end
    pulse_done(2);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL reissue_idle: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_async_reset();
    int at;
    sb.push_back(mk(3'b010, 4'h7, 1'b1));
    req = 3'b010;
    wait_grant(at);
    req = 3'b000;
    pulse_done(1);
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1 || lcd_msg_o !== 4'h7) begin
      n_bad++;
      $display("FAIL in_hold: got busy=%b code=%h, expected 1 7", busy_o, lcd_msg_o);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (gnt_o !== 3'b000 || lcd_start_o !== 1'b0 || lcd_msg_o !== 4'h0 || owner_o !== 2'd2 ||
        busy_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got gnt=%b start=%b code=%h owner=%0d busy=%b err=%b, expected 000 0 0 2 1 0",
               gnt_o, lcd_start_o, lcd_msg_o, owner_o, busy_o, err_o);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_dup_suppress();
    test_timeout();
    test_ready_drop();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending grants, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
